// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory sequencer.
package dmem_access_pkg;

    // Sequencer states: issue from IDLE, wait for the memory, one cycle of results.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmemState_t;

    // Funct3 encodings of the RV32 loads and stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access width after decoding Funct3; unused codes fall back to a word.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } accessSize_t;

    function automatic accessSize_t decodeSize(input logic [2:0] funct3);
        accessSize_t size;
        case (funct3)
            F3_B, F3_BU: size = SIZE_BYTE;
            F3_H, F3_HU: size = SIZE_HALF;
            default:     size = SIZE_WORD;
        endcase
        return size;
    endfunction

    // A halfword must sit on an even address and a word on a multiple of four.
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLow);
        logic mis;
        case (decodeSize(funct3))
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addrLow[0];
            default:   mis = (addrLow != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_lsu_format.sv
// Byte-lane steering for stores and extraction/extension for loads.
module lsu_format
    import dmem_access_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] readWord_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] loadData_o
);

    logic [31:0] shiftedWord;

    // Replicate the right-aligned store data into every lane and enable only the addressed ones.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = storeData_i;
        case (decodeSize(funct3_i))
            SIZE_BYTE: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{storeData_i[7:0]}};
            end
            SIZE_HALF: begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{storeData_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = storeData_i;
            end
        endcase
    end

    // Move the addressed bytes down to bit 0, then sign- or zero-extend by Funct3.
    always_comb begin
        shiftedWord = readWord_i >> {addr_i, 3'b000};
        case (funct3_i)
            F3_B:    loadData_o = {{24{shiftedWord[7]}}, shiftedWord[7:0]};
            F3_BU:   loadData_o = {24'h000000, shiftedWord[7:0]};
            F3_H:    loadData_o = {{16{shiftedWord[15]}}, shiftedWord[15:0]};
            F3_HU:   loadData_o = {16'h0000, shiftedWord[15:0]};
            default: loadData_o = shiftedWord;
        endcase
    end

endmodule

// File: rtl/flopr.sv
// Resettable D register used for every piece of sequencer state.
module flopr #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Synchronous active-high reset, otherwise load the next value every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: runs one req/ack transaction per load/store, stalling
// the front of the pipeline and bubbling writeback while it is outstanding.
module dmem_access_ctrl
    import dmem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] LoadDataM,
    output logic        StallM,
    output logic        FlushW,
    output logic        MisalignExc,
    output logic        BusErrExc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]       stateBits_q;
    dmemState_t       state_q;
    dmemState_t       state_d;
    logic [CNT_W-1:0] waitCnt_q;
    logic [CNT_W-1:0] waitCnt_d;
    logic [31:0]      loadWord_q;
    logic [31:0]      loadWord_d;
    logic             busErr_q;
    logic             busErr_d;

    logic        accessSeen;
    logic        isStore;
    logic        misaligned;
    logic        driveBus;
    logic [3:0]  fmtBe;
    logic [31:0] fmtWdata;
    logic [31:0] fmtLoad;

    flopr #(.WIDTH(2)) stateReg (
        .clk   (clk),
        .reset (reset),
        .d     (state_d),
        .q     (stateBits_q)
    );

    assign state_q = dmemState_t'(stateBits_q);

    flopr #(.WIDTH(CNT_W)) waitCntReg (
        .clk   (clk),
        .reset (reset),
        .d     (waitCnt_d),
        .q     (waitCnt_q)
    );

    flopr #(.WIDTH(32)) loadWordReg (
        .clk   (clk),
        .reset (reset),
        .d     (loadWord_d),
        .q     (loadWord_q)
    );

    flopr #(.WIDTH(1)) busErrReg (
        .clk   (clk),
        .reset (reset),
        .d     (busErr_d),
        .q     (busErr_q)
    );

    // Stores format the live EX/MEM operands; loads format the captured word.
    lsu_format formatter (
        .addr_i      (ALUResultM[1:0]),
        .funct3_i    (Funct3M),
        .storeData_i (WriteDataM),
        .readWord_i  (loadWord_q),
        .be_o        (fmtBe),
        .wdata_o     (fmtWdata),
        .loadData_o  (fmtLoad)
    );

    // An access held while reset is high must not start a transaction.
    assign accessSeen = (MemReadM | MemWriteM) & ~reset;
    assign isStore    = MemWriteM;
    assign misaligned = isMisaligned(Funct3M, ALUResultM[1:0]);

    // Next-state and output decode; EX/MEM is frozen while stalled, so bus fields driven from it stay stable.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        loadWord_d  = loadWord_q;
        busErr_d    = busErr_q;
        driveBus    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'h0000_0000;
        mem_be      = 4'b0000;
        mem_wdata   = 32'h0000_0000;
        LoadDataM   = 32'h0000_0000;
        StallM      = 1'b0;
        FlushW      = 1'b0;
        MisalignExc = 1'b0;
        BusErrExc   = 1'b0;

        case (state_q)
            IDLE: begin
                waitCnt_d = '0;
                if (accessSeen) begin
                    if (misaligned) begin
                        MisalignExc = 1'b1;
                    end else begin
                        driveBus = 1'b1;
                        busErr_d = 1'b0;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                driveBus = 1'b1;
                if (mem_ack) begin
                    loadWord_d = mem_rdata;
                    state_d    = DONE;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                    if (waitCnt_d == CNT_W'(TIMEOUT)) begin
                        busErr_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                BusErrExc = busErr_q;
                if (!busErr_q && !isStore) begin
                    LoadDataM = fmtLoad;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (driveBus) begin
            mem_req   = 1'b1;
            mem_we    = isStore;
            mem_addr  = {ALUResultM[31:2], 2'b00};
            mem_be    = isStore ? fmtBe : 4'b0000;
            mem_wdata = isStore ? fmtWdata : 32'h0000_0000;
            StallM    = 1'b1;
            FlushW    = 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural memory/format model.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] LoadDataM;
    logic        StallM;
    logic        FlushW;
    logic        MisalignExc;
    logic        BusErrExc;

    int errors = 0;
    int checks = 0;

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .Funct3M     (Funct3M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .LoadDataM   (LoadDataM),
        .StallM      (StallM),
        .FlushW      (FlushW),
        .MisalignExc (MisalignExc),
        .BusErrExc   (BusErrExc)
    );

    // Access size in bytes for a Funct3 code.
    function automatic int sizeOf(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Expected load result: pick the bytes arithmetically, then extend.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
        logic [31:0] v;
        int sz;
        sz = sizeOf(f3);
        v  = word >> (8 * int'(off));
        if (sz == 1) begin
            v = v % 256;
            if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v % 65536;
            if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Expected byte enables: lanes covered by [off, off+size).
    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        int sz;
        sz = sizeOf(f3);
        for (int lane = 0; lane < 4; lane++) begin
            be[lane] = (lane >= int'(off)) && (lane < int'(off) + sz);
        end
        return be;
    endfunction

    // Expected store data: each lane carries byte (lane mod size) of the source.
    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int sz;
        sz = sizeOf(f3);
        for (int lane = 0; lane < 4; lane++) begin
            w[8*lane +: 8] = 8'(wd >> (8 * (lane % sz)));
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One cycle with no access in MEM; everything must stay quiet.
    task automatic idleStep(input string tag, input logic ack);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mem_ack   = ack;
        mem_rdata = 32'hA5A5_5A5A;
        @(negedge clk);
        checkOutput({tag, "_req"},   32'(mem_req),   32'd0);
        checkOutput({tag, "_stall"}, 32'(StallM),    32'd0);
        checkOutput({tag, "_load"},  LoadDataM,      32'd0);
        checkOutput({tag, "_buserr"},32'(BusErrExc), 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    // Present one load/store, acknowledge it ackDelay cycles after issue, check the whole transaction.
    task automatic doAccess(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                            input int ackDelay, output logic [31:0] obsLoad);
        int  sz;
        int  doneAt;
        int  stalls;
        int  expDone;
        logic timedOut;
        logic mis;
        sz       = sizeOf(f3);
        mis      = (int'(addr[1:0]) % sz) != 0;
        timedOut = !(ackDelay >= 1 && ackDelay <= TIMEOUT);
        expDone  = timedOut ? TIMEOUT + 1 : ackDelay + 1;
        obsLoad  = 32'h0;
        applyStimulus(rd, wr, f3, addr, wd);
        mem_rdata = rdata;
        mem_ack   = 1'b0;
        if (mis) begin
            @(negedge clk);
            checkOutput({tag, "_misalign"}, 32'(MisalignExc), 32'd1);
            checkOutput({tag, "_mis_req"},  32'(mem_req),     32'd0);
            checkOutput({tag, "_mis_stall"},32'(StallM),      32'd0);
            @(posedge clk);
            #1;
            return;
        end
        doneAt = -1;
        stalls = 0;
        for (int c = 0; c < TIMEOUT + 4 && doneAt < 0; c++) begin
            mem_ack = (c == ackDelay);
            @(negedge clk);
            if (c == 0) begin
                checkOutput({tag, "_req"},  32'(mem_req),  32'd1);
                checkOutput({tag, "_we"},   32'(mem_we),   32'(wr));
                checkOutput({tag, "_addr"}, mem_addr,      addr - (addr % 4));
                checkOutput({tag, "_flush"},32'(FlushW),   32'd1);
                if (wr) begin
                    checkOutput({tag, "_be"},    32'(mem_be), 32'(modelBe(f3, addr[1:0])));
                    checkOutput({tag, "_wdata"}, mem_wdata,   modelWdata(f3, wd));
                end
            end
            if (StallM === 1'b1) begin
                stalls++;
            end else begin
                doneAt  = c;
                obsLoad = LoadDataM;
                checkOutput({tag, "_done_req"}, 32'(mem_req),   32'd0);
                checkOutput({tag, "_done_load"}, LoadDataM,
                            (timedOut || wr) ? 32'h0 : modelLoad(f3, addr[1:0], rdata));
                checkOutput({tag, "_buserr"},   32'(BusErrExc), 32'(timedOut));
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        checkOutput({tag, "_done_cycle"}, 32'(doneAt), 32'(expDone));
        checkOutput({tag, "_stalls"},     32'(stalls), 32'(expDone));
    endtask

    logic [2:0] loadCodes  [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic [2:0] storeCodes [3] = '{3'b000, 3'b001, 3'b010};

    // Directed scenarios followed by a randomized stream.
    initial begin
        logic [31:0] obs;
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req",   32'(mem_req),     32'd0);
        checkOutput("rst_stall", 32'(StallM),      32'd0);
        checkOutput("rst_flush", 32'(FlushW),      32'd0);
        checkOutput("rst_load",  LoadDataM,        32'd0);
        checkOutput("rst_mis",   32'(MisalignExc), 32'd0);
        checkOutput("rst_bus",   32'(BusErrExc),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idleStep("post_rst", 1'b0);

        doAccess("lw_1000", 1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1, obs);
        checkOutput("lw_1000_value", obs, 32'hDEAD_BEEF);
        idleStep("lw_after1", 1'b0);
        idleStep("lw_after2", 1'b0);

        doAccess("lb_1003", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8012_3456, 1, obs);
        checkOutput("lb_1003_value", obs, 32'hFFFF_FF80);
        doAccess("lbu_1003", 1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h8012_3456, 2, obs);
        checkOutput("lbu_1003_value", obs, 32'h0000_0080);

        doAccess("sh_2002", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0, 1, obs);
        doAccess("lw_1001", 1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'h0, 32'h0, 1, obs);
        idleStep("mis_after", 1'b0);

        doAccess("lw_tmo", 1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h1111_2222, 99, obs);
        idleStep("tmo_gap", 1'b0);
        idleStep("tmo_late_ack", 1'b1);

        // Reset lands in the third WAIT cycle of a load that is never acknowledged.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0);
        mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rstw_stall", 32'(StallM), 32'd1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstw_req_held", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rstw_req_drop", 32'(mem_req), 32'd0);
        checkOutput("rstw_stall_drop", 32'(StallM), 32'd0);
        @(posedge clk);
        #1;
        doAccess("sw_after_rst", 1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 1, obs);

        for (int i = 0; i < 40; i++) begin
            logic        rd;
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          kind;
            int          off;
            int          sz;
            kind = int'($urandom_range(0, 2));
            rd   = (kind != 1);
            wr   = (kind != 0);
            f3   = wr ? storeCodes[$urandom_range(0, 2)] : loadCodes[$urandom_range(0, 7)];
            sz   = sizeOf(f3);
            off  = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) off = off - (off % sz);
            addr = $urandom;
            addr[1:0] = 2'(off);
            doAccess("rand", rd, wr, f3, addr, $urandom, $urandom,
                     int'($urandom_range(1, TIMEOUT + 2)), obs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

MEM-stage data-memory sequencer for the pipelined RV32 core. It takes the load/store held in the EX/MEM pipeline register and runs a req/ack transaction with a variable-latency data memory. While the access is outstanding it stalls the front of the pipeline and bubbles writeback. It formats store byte-enables and load data, and flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT`, default 255: maximum WAIT cycles without `mem_ack` before the access is abandoned.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `MemReadM` in 1: MEM stage holds a load.
- `MemWriteM` in 1: MEM stage holds a store.
- `Funct3M` in 3: access size/sign. Valid codes: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `ALUResultM` in 32: byte address.
- `WriteDataM` in 32: store data, right-aligned.
- `mem_req` out 1: request, held until ack or timeout.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{ALUResultM[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-aligned store data.
- `mem_ack` in 1: one-cycle completion pulse.
- `mem_rdata` in 32: read word, valid with `mem_ack`.
- `LoadDataM` out 32: extended load result to the MEM/WB register.
- `StallM` out 1: freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- `FlushW` out 1: loads a bubble into MEM/WB.
- `MisalignExc` out 1: one-cycle pulse.
- `BusErrExc` out 1: one-cycle pulse.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE, no access** (`MemReadM` = `MemWriteM` = 0): all outputs 0, stay IDLE.
- **IDLE, misaligned access** (LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0):
  - `MisalignExc`=1 combinationally; no request; `StallM`=0.
  - Stay IDLE; the instruction proceeds.
- **IDLE, aligned access:**
  - `mem_req`=1 and `StallM`=`FlushW`=1 combinationally; next state WAIT; timeout counter cleared.
- **WAIT:**
  - `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` held stable; `StallM`=`FlushW`=1.
  - `mem_ack`=1: capture `mem_rdata` into the load register, go to DONE.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT`, go to DONE with the error flag set.
- **DONE:**
  - `mem_req`=0, `StallM`=0, `FlushW`=0.
  - `LoadDataM` = formatted captured word; 0 on timeout or store.
  - `BusErrExc`=1 if the error flag is set.
  - Next state IDLE unconditionally, so the same instruction is never reissued.
- Read and write asserted together: treated as a store.
- Funct3 codes 011, 110, 111: treated as word access.
- **Store formatting:**
  - SB: `be`=`1<<addr[1:0]`, data = byte replicated ×4.
  - SH: `be`=0011 or 1100 by `addr[1]`, data = halfword replicated ×2.
  - SW: `be`=1111.
- **Load formatting:** shift the word right by `8*addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU). All arithmetic is unsigned 32-bit.
- `mem_ack` is ignored outside WAIT; a late ack after timeout has no effect.
- Counter width is `$clog2(TIMEOUT+1)`.

## Timing
- Reset: state IDLE, counter 0, load register 0, error flag 0.
- Every output is 0 during and after the reset edge until a new access is seen in IDLE.
- A reset during WAIT drops `mem_req` on the next edge; the memory must tolerate an abandoned request.
- Minimum access is 3 cycles: IDLE (issue), WAIT (ack), DONE. That gives 2 stall cycles.
- `mem_ack` in the same cycle as issue from IDLE is ignored. Memory acks no earlier than the cycle after `mem_req` rises.
- Back-to-back accesses: the next instruction enters MEM on the edge ending DONE and is evaluated in IDLE that cycle. There is no extra bubble.
- Timeout: `BusErrExc` rises in DONE, exactly `TIMEOUT`+1 cycles after issue.

## Structure
- `dmem_access_pkg` holds:
  - the state enum (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - the `Funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
- One combinational sub-module, `lsu_format`. Inputs: `addr[1:0]`, `Funct3`, store data, raw read word. Outputs: `be`, `wdata`, extended load data.
- The controller instantiates `lsu_format` and `flopr`-style registers for state, counter, load word and error flag.

## Test plan
- LW at 0x1000, ack 1 cycle after req, `rdata`=0xDEADBEEF:
  - `StallM` high 2 cycles;
  - `LoadDataM`=0xDEADBEEF in DONE;
  - `mem_req` never reasserts.
- LB at 0x1003 with `rdata` 0x80xxxxxx → `LoadDataM`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x2002, data 0x1234 → `mem_be`=1100, `mem_wdata`=0x12341234, `mem_we`=1, `mem_addr`=0x2000.
- LW at 0x1001 → `MisalignExc` 1 cycle, `mem_req`=0, `StallM`=0.
- No ack with `TIMEOUT`=4 → `BusErrExc` pulse 5 cycles after issue, `LoadDataM`=0. An ack arriving 2 cycles later is ignored.
- Reset asserted in the 3rd WAIT cycle → `mem_req`=0 next cycle, state IDLE. A subsequent SW completes normally.
